pc_unit: RTL and testbench

Parametrised program-counter unit: the successor to the plain enable-gated 32-bit PC register in the fetch stage. It holds the PC and selects the next value from sequential increment, branch/jump target, return-address-stack pop, trap vector, or exception return. It also owns the exception PC (EPC) and a circular return-address stack (RAS). All state is registered on one clock edge; there is no combinational path from any input to any output.

---
 rtl/pc_unit.sv | 106 ++++++++++
 tb/tb_pc_unit.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: program counter with trap/exception return and a circular return-address stack.
// Ports:
//   CLK, RST (sync, active-high)
//   PC_EN      advance enable (0 = stall; TRAP still acts)
//   BR_TAKEN   redirect to BR_TARGET; with CALL also pushes PC+INC
//   RET        pop the RAS and jump to the popped address
//   TRAP       EPC <= PC, PC <= TRAP_VEC
//   ERET       PC <= EPC
//   PC, EPC    registered program counter and exception PC
//   RAS_COUNT  valid RAS entries; RAS_EMPTY / RAS_FULL decoded from it
//   RAS_MISS   one-cycle pulse when RET found the RAS empty
module pc_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100,
    parameter int              INC       = 4,
    parameter int              RAS_DEPTH = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         PC_EN,
    input  logic                         BR_TAKEN,
    input  logic [XLEN-1:0]              BR_TARGET,
    input  logic                         CALL,
    input  logic                         RET,
    input  logic                         TRAP,
    input  logic                         ERET,
    output logic [XLEN-1:0]              PC,
    output logic [XLEN-1:0]              EPC,
    output logic [$clog2(RAS_DEPTH):0]   RAS_COUNT,
    output logic                         RAS_EMPTY,
    output logic                         RAS_FULL,
    output logic                         RAS_MISS
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] pc, epc;
    logic [XLEN-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]   top;
    logic [CW-1:0]   cnt;
    logic            miss;
    logic [XLEN-1:0] pc_inc;
    logic [PW-1:0]   top_up;
    logic            push;

    assign pc_inc = pc + XLEN'(INC);
    // top indexes the most recent entry; a push pre-increments, so the pointer
    // wraps onto the oldest slot when the stack is full.
    assign top_up = top + PW'(1);
    assign push   = BR_TAKEN && CALL;

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc   <= RESET_VEC;
            epc  <= '0;
            top  <= '0;
            cnt  <= '0;
            miss <= 1'b0;
        end else begin
            miss <= 1'b0;
            if (TRAP) begin
                epc <= pc;
                pc  <= TRAP_VEC;
            end else if (PC_EN) begin
                if (ERET) begin
                    pc <= epc;
                end else if (RET && cnt == '0) begin
                    // underflow: fall back to the supplied target, still honour a call
                    pc   <= BR_TARGET;
                    miss <= 1'b1;
                    if (push) begin
                        top      <= top_up;
                        ras[top_up] <= pc_inc;
                        cnt      <= CW'(1);
                    end
                end else if (RET) begin
                    pc <= ras[top];
                    // pop and push in the same cycle cancel: replace the top slot in place
                    if (push) begin
                        ras[top] <= pc_inc;
                    end else begin
                        top <= top - PW'(1);
                        cnt <= cnt - CW'(1);
                    end
                end else if (BR_TAKEN) begin
                    pc <= BR_TARGET;
                    if (CALL) begin
                        top         <= top_up;
                        ras[top_up] <= pc_inc;
                        cnt         <= (cnt == CW'(RAS_DEPTH)) ? cnt : cnt + CW'(1);
                    end
                end else begin
                    pc <= pc_inc;
                end
            end
        end
    end

    assign PC        = pc;
    assign EPC       = epc;
    assign RAS_COUNT = cnt;
    assign RAS_EMPTY = (cnt == '0);
    assign RAS_FULL  = (cnt == CW'(RAS_DEPTH));
    assign RAS_MISS  = miss;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: table-driven, scoreboarded bench for pc_unit (XLEN=32, RAS_DEPTH=4).
module tb_pc_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_en = 1'b0, br_taken = 1'b0, call = 1'b0, ret = 1'b0, trap = 1'b0, eret = 1'b0;
    logic [31:0] br_target = '0;
    logic [31:0] pc, epc;
    logic [2:0]  ras_count;
    logic        ras_empty, ras_full, ras_miss;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rst, en, br, call, ret, trap, eret;
        logic [31:0] tgt;
        logic [31:0] pc, epc;
        logic [2:0]  cnt;
        logic        miss;
        int          idx;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    pc_unit #(.XLEN(32), .RESET_VEC(32'h0), .TRAP_VEC(32'h100), .INC(4), .RAS_DEPTH(4)) dut (
        .CLK(clk), .RST(rst), .PC_EN(pc_en), .BR_TAKEN(br_taken), .BR_TARGET(br_target),
        .CALL(call), .RET(ret), .TRAP(trap), .ERET(eret),
        .PC(pc), .EPC(epc), .RAS_COUNT(ras_count), .RAS_EMPTY(ras_empty),
        .RAS_FULL(ras_full), .RAS_MISS(ras_miss)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(input logic r, en, br, cl, rt, tp, er, input logic [31:0] tgt,
                               input logic [31:0] epc_pc, e, input logic [2:0] c, input logic m);
        vec_t x;
        x.rst = r; x.en = en; x.br = br; x.call = cl; x.ret = rt; x.trap = tp; x.eret = er;
        x.tgt = tgt; x.pc = epc_pc; x.epc = e; x.cnt = c; x.miss = m; x.idx = 0;
        return x;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Scoreboard consumer: each edge retires the oldest driven vector.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            vec_t e;
            e = sb.pop_front();
            chk("pc", e.idx, pc, e.pc);
            chk("epc", e.idx, epc, e.epc);
            chk("ras_count", e.idx, 32'(ras_count), 32'(e.cnt));
            chk("ras_empty", e.idx, 32'(ras_empty), 32'(e.cnt == 3'd0));
            chk("ras_full", e.idx, 32'(ras_full), 32'(e.cnt == 3'd4));
            chk("ras_miss", e.idx, 32'(ras_miss), 32'(e.miss));
        end
    end

    initial begin
        //          rst en br cl rt tp er  target         pc             epc        cnt miss
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,     0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,     0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h4,        32'h0,     0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h8,        32'h0,     0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 0, 32'h0,        32'hC,        32'h0,     0, 0));
        // stall and wrap; stalled RET/CALL/ERET must be ignored without a miss
        vecs.push_back(v(0, 1, 1, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,   0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'hFFFF_FFFC, 32'h0,    0, 0));
        vecs.push_back(v(0, 0, 1, 1, 1, 0, 1, 32'h1234,     32'hFFFF_FFFC, 32'h0,    0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,     0, 0));
        // call/return nesting
        vecs.push_back(v(0, 1, 1, 0, 0, 0, 0, 32'h10,       32'h10,       32'h0,     0, 0));
        vecs.push_back(v(0, 1, 1, 1, 0, 0, 0, 32'h100,      32'h100,      32'h0,     1, 0));
        vecs.push_back(v(0, 1, 1, 1, 0, 0, 0, 32'h200,      32'h200,      32'h0,     2, 0));
        vecs.push_back(v(0, 1, 0, 0, 1, 0, 0, 32'h0,        32'h104,      32'h0,     1, 0));
        vecs.push_back(v(0, 1, 0, 0, 1, 0, 0, 32'h0,        32'h14,       32'h0,     0, 0));
        vecs.push_back(v(0, 1, 0, 1, 0, 0, 0, 32'h999,      32'h18,       32'h0,     0, 0));
        // overflow: A1..A5 = 1C, 1004, 2004, 3004, 4004
        vecs.push_back(v(0, 1, 1, 1, 0, 0, 0, 32'h1000,     32'h1000,     32'h0,     1, 0));
        vecs.push_back(v(0, 1, 1, 1, 0, 0, 0, 32'h2000,     32'h2000,     32'h0,     2, 0));
        vecs.push_back(v(0, 1, 1, 1, 0, 0, 0, 32'h3000,     32'h3000,     32'h0,     3, 0));
        vecs.push_back(v(0, 1, 1, 1, 0, 0, 0, 32'h4000,     32'h4000,     32'h0,     4, 0));
        vecs.push_back(v(0, 1, 1, 1, 0, 0, 0, 32'h5000,     32'h5000,     32'h0,     4, 0));
        vecs.push_back(v(0, 1, 0, 0, 1, 0, 0, 32'h777,      32'h4004,     32'h0,     3, 0));
        vecs.push_back(v(0, 1, 0, 0, 1, 0, 0, 32'h777,      32'h3004,     32'h0,     2, 0));
        vecs.push_back(v(0, 1, 0, 0, 1, 0, 0, 32'h777,      32'h2004,     32'h0,     1, 0));
        vecs.push_back(v(0, 1, 0, 0, 1, 0, 0, 32'h777,      32'h1004,     32'h0,     0, 0));
        vecs.push_back(v(0, 1, 0, 0, 1, 0, 0, 32'h777,      32'h777,      32'h0,     0, 1));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h77B,      32'h0,     0, 0));
        // trap / eret
        vecs.push_back(v(0, 1, 1, 0, 0, 0, 0, 32'h40,       32'h40,       32'h0,     0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 1, 0, 32'h0,        32'h100,      32'h40,    0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 1, 1, 32'h0,        32'h100,      32'h100,   0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 1, 32'h0,        32'h100,      32'h100,   0, 0));
        vecs.push_back(v(0, 1, 1, 1, 1, 0, 1, 32'h999,      32'h100,      32'h100,   0, 0));
        // RET+CALL+BR with top = 0x80 at PC = 0x20, then read back the replaced slot
        vecs.push_back(v(0, 1, 1, 0, 0, 0, 0, 32'h7C,       32'h7C,       32'h100,   0, 0));
        vecs.push_back(v(0, 1, 1, 1, 0, 0, 0, 32'h500,      32'h500,      32'h100,   1, 0));
        vecs.push_back(v(0, 1, 1, 0, 0, 0, 0, 32'h20,       32'h20,       32'h100,   1, 0));
        vecs.push_back(v(0, 1, 1, 1, 1, 0, 0, 32'h900,      32'h80,       32'h100,   1, 0));
        vecs.push_back(v(0, 1, 0, 0, 1, 0, 0, 32'h0,        32'h24,       32'h100,   0, 0));
        // same collision on an empty RAS
        vecs.push_back(v(0, 1, 1, 1, 1, 0, 0, 32'h600,      32'h600,      32'h100,   1, 1));
        vecs.push_back(v(0, 1, 0, 0, 1, 0, 0, 32'h0,        32'h28,       32'h100,   0, 0));
        // reset wins over trap; reset mid-sequence clears the RAS count
        vecs.push_back(v(1, 1, 0, 0, 0, 1, 0, 32'h0,        32'h0,        32'h0,     0, 0));
        vecs.push_back(v(0, 1, 1, 1, 0, 0, 0, 32'h300,      32'h300,      32'h0,     1, 0));
        vecs.push_back(v(1, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,     0, 0));
        vecs.push_back(v(0, 1, 0, 0, 1, 0, 0, 32'h50,       32'h50,       32'h0,     0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t x;
            @(negedge clk);
            x = vecs[i];
            x.idx = i;
            rst = x.rst; pc_en = x.en; br_taken = x.br; call = x.call;
            ret = x.ret; trap = x.trap; eret = x.eret; br_target = x.tgt;
            sb.push_back(x);
        end
        @(negedge clk);
        pc_en = 1'b0; br_taken = 1'b0; call = 1'b0; ret = 1'b0; trap = 1'b0; eret = 1'b0;
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        chk("scoreboard_drain", 0, 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
